// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding and one-hot helper for decoder_scan_n
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Widest one-hot vector the helper can build (supports N up to 8).
    localparam int unsigned ONEHOT_MAX_W = 256;

    // One-hot of idx within a 2^n wide field; out-of-range idx gives all zeros.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if (idx < (32'd1 << n)) begin
            v[idx[7:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_n_dwell_counter.sv
// rtl/decoder_scan_n_dwell_counter.sv - clearable up-counter with terminal-count flag at a programmable limit
module dwell_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Clear wins over increment so a state change always restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == limit);

endmodule

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2^N decoder with manual and scan modes and blanking gap
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DWELL      = 4,
    parameter int unsigned BLANK      = 1,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      a,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int unsigned NOUT      = 1 << N;
    localparam int unsigned CMAX      = ((DWELL > BLANK) ? DWELL : BLANK) - 1;
    localparam int unsigned CW        = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [N-1:0]  IDX_LAST  = N'(NOUT - 1);
    localparam logic [CW-1:0] LIM_DWELL = CW'(DWELL - 1);
    localparam logic [CW-1:0] LIM_BLANK = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam state_e        ST_FIRST  = (BLANK > 0) ? ST_BLANK : ST_DRIVE;
    localparam logic [NOUT-1:0] Y_IDLE  = ACTIVE_LOW ? {NOUT{1'b1}} : {NOUT{1'b0}};

    state_e                  state_q, state_d;
    logic [N-1:0]            idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    logic                    mode_q, mode_d;
    logic [NOUT-1:0]         y_q, y_d;
    logic                    cnt_clr, cnt_inc, cnt_tc;
    logic [CW-1:0]           cnt_limit;
    logic [CW-1:0]           cnt_val;
    logic [ONEHOT_MAX_W-1:0] oh;

    // One counter serves both the blank gap and the dwell time.
    assign cnt_limit = (state_q == ST_BLANK) ? LIM_BLANK : LIM_DWELL;

    dwell_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .cnt   (cnt_val),
        .tc    (cnt_tc)
    );

    // Next state, index and wrap; en=0 overrides everything, then leaving OFF, then mode changes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        mode_d  = mode;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_clr = 1'b1;
        end else if (state_q == ST_OFF || mode != mode_q) begin
            state_d = ST_FIRST;
            cnt_clr = 1'b1;
            if (!mode) begin
                idx_d = a;
            end
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (!mode && a != idx_q) begin
                        idx_d   = a;
                        cnt_clr = 1'b1;
                    end else if (cnt_tc) begin
                        state_d = ST_DRIVE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (mode) begin
                        if (cnt_tc) begin
                            idx_d   = idx_q + 1'b1;
                            wrap_d  = (idx_q == IDX_LAST);
                            state_d = ST_FIRST;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (a != idx_q) begin
                        idx_d   = a;
                        state_d = ST_FIRST;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Output is built from the next state so y never shows a stale index.
    always_comb begin
        oh  = onehot(32'(idx_d), N);
        y_d = (state_d == ST_DRIVE) ? oh[NOUT-1:0] : '0;
        if (ACTIVE_LOW) begin
            y_d = ~y_d;
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= 1'b0;
            y_q     <= Y_IDLE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - randomized and directed bench for decoder_scan_n against a countdown model
module tb_decoder_scan_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] a = 2'd0;
    logic [3:0] y0, y1;
    logic [1:0] idx0, idx1;
    logic       wrap0, wrap1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    decoder_scan_n #(.N(2), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y0), .idx(idx0), .wrap(wrap0)
    );

    decoder_scan_n #(.N(2), .DWELL(4), .BLANK(0), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
        .y(y1), .idx(idx1), .wrap(wrap1)
    );

    typedef struct {
        bit on;
        int blank_left;
        int drive_left;
        int idx;
        bit prev_mode;
        bit wrap;
    } model_t;

    model_t m0, m1;

    function automatic model_t step(model_t m, bit r, bit e, bit md, int aa, int blank, int dwell);
        model_t n = m;
        n.wrap = 1'b0;
        if (!r) begin
            n.on = 1'b0; n.idx = 0; n.prev_mode = 1'b0;
            return n;
        end
        if (!e) begin
            n.on = 1'b0;
        end else if (!m.on || md != m.prev_mode) begin
            n.on = 1'b1; n.blank_left = blank; n.drive_left = dwell;
            if (!md) n.idx = aa;
        end else if (m.blank_left > 0) begin
            if (!md && aa != m.idx) begin
                n.idx = aa; n.blank_left = blank;
            end else begin
                n.blank_left = m.blank_left - 1;
                n.drive_left = dwell;
            end
        end else if (md) begin
            n.drive_left = m.drive_left - 1;
            if (n.drive_left == 0) begin
                n.wrap = (m.idx == 3);
                n.idx = (m.idx + 1) % 4;
                n.blank_left = blank;
                n.drive_left = dwell;
            end
        end else if (aa != m.idx) begin
            n.idx = aa; n.blank_left = blank;
        end
        n.prev_mode = md;
        return n;
    endfunction

    function automatic logic [3:0] exp_y(model_t m, bit al);
        logic [3:0] v;
        v = (m.on && m.blank_left == 0) ? 4'(1 << m.idx) : 4'b0000;
        return al ? ~v : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit md, input logic [1:0] aa);
        rst_n = r; en = e; mode = md; a = aa;
        @(posedge clk);
        m0 = step(m0, r, e, md, int'(aa), 1, 4);
        m1 = step(m1, r, e, md, int'(aa), 0, 4);
        cyc++;
        #1;
        check("y0", 32'(y0), 32'(exp_y(m0, 1'b0)));
        check("idx0", 32'(idx0), 32'(m0.idx));
        check("wrap0", 32'(wrap0), 32'(m0.wrap));
        check("y1", 32'(y1), 32'(exp_y(m1, 1'b1)));
        check("idx1", 32'(idx1), 32'(m1.idx));
        check("wrap1", 32'(wrap1), 32'(m1.wrap));
    endtask

    initial begin
        bit r, e, md;
        logic [1:0] aa;
        int guard;
        m0 = '{default: 0};
        m1 = '{default: 0};

        // reset with en=1, scan mode
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        check("rst_y0", 32'(y0), 32'h0);
        check("rst_y1", 32'(y1), 32'hF);
        check("rst_wrap0", 32'(wrap0), 32'h0);

        // first scan frames
        cycle(1'b1, 1'b1, 1'b1, 2'd0);
        check("blank_first", 32'(y0), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 2'd0);
        check("drive_first", 32'(y0), 32'h1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0);

        // manual select, repeat, and glitch during blank
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 2'd2);
        check("man_a2", 32'(y0), 32'h4);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 2'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'd3);
        cycle(1'b1, 1'b1, 1'b0, 2'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'd3);
        cycle(1'b1, 1'b1, 1'b0, 2'd1);
        check("glitch_blank", 32'(y0), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 2'd1);
        check("glitch_drive", 32'(y0), 32'h2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 2'd1);

        // en drop mid-drive at idx 2 in scan mode
        guard = 0;
        cycle(1'b1, 1'b1, 1'b1, 2'd0);
        while (!(m0.idx == 2 && m0.blank_left == 0 && m0.on) && guard < 40) begin
            cycle(1'b1, 1'b1, 1'b1, 2'd0);
            guard++;
        end
        check("reach_idx2", 32'(guard < 40), 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 2'd0);
        check("en_off_y", 32'(y0), 32'h0);
        check("en_off_idx", 32'(idx0), 32'h2);
        cycle(1'b1, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0);

        // randomized traffic
        r = 1'b1; e = 1'b1; md = 1'b1; aa = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) e = ~e;
            if ($urandom_range(0, 29) == 0) md = ~md;
            if ($urandom_range(0, 5) == 0) aa = 2'($urandom_range(0, 3));
            cycle(r, e, md, aa);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
